card_compare: RTL and testbench

- Downstream consumer of the game-flow state machine; it implements the COMPARE_CARDS step.
- Once two cards have been discovered, it checks their colours and acts on the result:
  - Match: marks the pair as solved.
  - Mismatch: holds both cards visible for a fixed time, then requests they be hidden.
- Also counts moves (BCD) and flags game completion for the renderer and end screen.

---
 rtl/card_compare_pkg.sv | 36 +++
 rtl/bcd_counter_2d.sv | 22 ++
 rtl/card_compare.sv | 135 +++++++++++++
 tb/tb_card_compare.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/card_compare_pkg.sv
// Shared board constants, compare-FSM state encodings and the BCD increment helper
// for the memory game.
package card_compare_pkg;

  localparam int unsigned N_CARDS_DEF     = 16;
  localparam int unsigned IDX_W_DEF       = 4;
  localparam int unsigned COLOR_W_DEF     = 3;
  localparam int unsigned CLK_HZ          = 65_000_000;
  localparam int unsigned SHOW_CYCLES_DEF = CLK_HZ;

  // 4-bit encodings, same width as the game-flow state machine's state register
  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StLatch    = 4'd1,
    StCheck    = 4'd2,
    StShowWait = 4'd3,
    StMark     = 4'd4,
    StHide     = 4'd5,
    StDone     = 4'd6,
    StRelease  = 4'd7
  } cmp_state_e;

  // Two-digit BCD increment, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] q);
    logic [7:0] r;
    if (q == 8'h99) begin
      r = 8'h99;
    end else if (q[3:0] == 4'd9) begin
      r = {q[7:4] + 4'd1, 4'd0};
    end else begin
      r = {q[7:4], q[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up-counter with synchronous clear; saturates at 99.
module bcd_counter_2d
  import card_compare_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 8'h00;
    end else if (clr) begin
      q <= 8'h00;
    end else if (inc) begin
      q <= bcd_inc(q);
    end
  end

endmodule

// File: rtl/card_compare.sv
// COMPARE_CARDS step: classifies a discovered pair, marks matches, times the
// mismatch display, requests hiding and keeps the move count.
module card_compare
  import card_compare_pkg::*;
#(
  parameter int unsigned N_CARDS     = N_CARDS_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF,
  parameter int unsigned COLOR_W     = COLOR_W_DEF,
  parameter int unsigned SHOW_CYCLES = SHOW_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_game,
  input  logic                       compare_en,
  input  logic [IDX_W-1:0]           first_idx,
  input  logic [IDX_W-1:0]           second_idx,
  input  logic [N_CARDS*COLOR_W-1:0] card_colors,
  output logic                       busy,
  output logic [N_CARDS-1:0]         matched_mask,
  output logic                       hide_valid,
  output logic [N_CARDS-1:0]         hide_mask,
  output logic                       pair_match,
  output logic                       compare_done,
  output logic                       game_won,
  output logic [7:0]                 moves_bcd
);

  localparam int unsigned CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);

  cmp_state_e         state;
  logic [IDX_W-1:0]   idx_a, idx_b;
  logic [COLOR_W-1:0] col_a, col_b;
  logic               pair_valid;
  logic [CNT_W-1:0]   wait_cnt;
  logic               moves_inc;

  assign busy = (state != StIdle);
  // Invalid pairs reach HIDE with pair_valid=0 and do not count as a move
  assign moves_inc = (state == StMark) || ((state == StHide) && pair_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      idx_a        <= '0;
      idx_b        <= '0;
      col_a        <= '0;
      col_b        <= '0;
      pair_valid   <= 1'b0;
      wait_cnt     <= '0;
      matched_mask <= '0;
      hide_valid   <= 1'b0;
      hide_mask    <= '0;
      pair_match   <= 1'b0;
      compare_done <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      hide_valid   <= 1'b0;
      hide_mask    <= '0;
      compare_done <= 1'b0;
      if (new_game) begin
        state        <= StIdle;
        matched_mask <= '0;
        pair_match   <= 1'b0;
        game_won     <= 1'b0;
        wait_cnt     <= '0;
        pair_valid   <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (compare_en) state <= StLatch;
          end
          StLatch: begin
            idx_a <= first_idx;
            idx_b <= second_idx;
            col_a <= card_colors[COLOR_W*first_idx +: COLOR_W];
            col_b <= card_colors[COLOR_W*second_idx +: COLOR_W];
            state <= StCheck;
          end
          StCheck: begin
            if ((idx_a == idx_b) || matched_mask[idx_a] || matched_mask[idx_b]) begin
              pair_valid <= 1'b0;
              pair_match <= 1'b0;
              state      <= StHide;
            end else if (col_a == col_b) begin
              pair_valid <= 1'b1;
              pair_match <= 1'b1;
              state      <= StMark;
            end else begin
              pair_valid <= 1'b1;
              pair_match <= 1'b0;
              wait_cnt   <= '0;
              state      <= StShowWait;
            end
          end
          StShowWait: begin
            if (wait_cnt == CNT_LAST) begin
              state <= StHide;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          StMark: begin
            matched_mask[idx_a] <= 1'b1;
            matched_mask[idx_b] <= 1'b1;
            state               <= StDone;
          end
          StHide: begin
            hide_valid <= 1'b1;
            hide_mask  <= (N_CARDS'(1) << idx_a) | (N_CARDS'(1) << idx_b);
            state      <= StDone;
          end
          StDone: begin
            compare_done <= 1'b1;
            game_won     <= &matched_mask;
            state        <= StRelease;
          end
          StRelease: begin
            if (!compare_en) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  bcd_counter_2d u_moves (
    .clk (clk),
    .rst (rst),
    .clr (new_game),
    .inc (moves_inc),
    .q   (moves_bcd)
  );

endmodule

// File: tb/tb_card_compare.sv
// Directed self-checking bench for card_compare with a short mismatch display time.
module tb_card_compare;

  localparam int unsigned SHOW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic        compare_en;
  logic [3:0]  first_idx;
  logic [3:0]  second_idx;
  logic [47:0] card_colors;
  logic        busy;
  logic [15:0] matched_mask;
  logic        hide_valid;
  logic [15:0] hide_mask;
  logic        pair_match;
  logic        compare_done;
  logic        game_won;
  logic [7:0]  moves_bcd;

  int n_tests = 0;
  int n_fail  = 0;

  card_compare #(
    .SHOW_CYCLES (SHOW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .compare_en   (compare_en),
    .first_idx    (first_idx),
    .second_idx   (second_idx),
    .card_colors  (card_colors),
    .busy         (busy),
    .matched_mask (matched_mask),
    .hide_valid   (hide_valid),
    .hide_mask    (hide_mask),
    .pair_match   (pair_match),
    .compare_done (compare_done),
    .game_won     (game_won),
    .moves_bcd    (moves_bcd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_color(input int idx, input logic [2:0] c);
    card_colors[3*idx +: 3] = c;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  // exp_hide_lat = 0 means no hide pulse is expected
  task automatic run_compare(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input int exp_lat, input int exp_hide_lat,
                             input logic [15:0] exp_hmask, input int hold);
    int lat, hide_lat, hide_cnt, stray, extra;
    logic [15:0] hmask;
    lat = -1; hide_lat = 0; hide_cnt = 0; stray = 0; extra = 0; hmask = '0;
    @(negedge clk);
    first_idx  = a;
    second_idx = b;
    compare_en = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        first_idx  = ~a;
        second_idx = ~b;
      end
      if (hide_valid) begin
        hide_cnt++;
        hide_lat = n;
        hmask    = hide_mask;
      end else if (hide_mask != '0) begin
        stray++;
      end
      if (compare_done) lat = n;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_hide_lat"}, hide_lat, exp_hide_lat);
    check_eq({tag, "_hide_mask"}, {16'h0, hmask}, {16'h0, exp_hmask});
    check_eq({tag, "_hide_pulses"}, hide_cnt, (exp_hide_lat != 0) ? 1 : 0);
    check_eq({tag, "_hide_mask_idle"}, stray, 0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (compare_done || !busy || hide_valid) extra++;
      end
      check_eq({tag, "_hold"}, extra, 0);
    end
    @(negedge clk);
    compare_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_release"}, busy, 1'b0);
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return 8'(((m / 10) << 4) | (m % 10));
  endfunction

  initial begin
    int quiet;
    rst         = 1'b1;
    new_game    = 1'b0;
    compare_en  = 1'b0;
    first_idx   = '0;
    second_idx  = '0;
    card_colors = '0;
    for (int i = 0; i < 16; i++) set_color(i, 3'(i));
    set_color(3, 3'd5);
    set_color(9, 3'd5);
    set_color(0, 3'd1);
    set_color(1, 3'd2);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_mask", matched_mask, 16'h0);
    check_eq("rst_moves", moves_bcd, 8'h00);
    check_eq("rst_flags", {hide_valid, pair_match, compare_done, game_won}, 4'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1. match
    run_compare("match", 4'd3, 4'd9, 4, 0, 16'h0, 0);
    check_eq("match_pair", pair_match, 1'b1);
    check_eq("match_mask", matched_mask, 16'h0208);
    check_eq("match_moves", moves_bcd, 8'h01);

    // 2. mismatch
    run_compare("mism", 4'd0, 4'd1, 4 + SHOW, 3 + SHOW, 16'h0003, 0);
    check_eq("mism_pair", pair_match, 1'b0);
    check_eq("mism_mask", matched_mask, 16'h0208);
    check_eq("mism_moves", moves_bcd, 8'h02);

    // 3. invalid pairs
    run_compare("same", 4'd7, 4'd7, 4, 3, 16'h0080, 0);
    check_eq("same_moves", moves_bcd, 8'h02);
    check_eq("same_pair", pair_match, 1'b0);
    run_compare("solved", 4'd3, 4'd4, 4, 3, 16'h0018, 0);
    check_eq("solved_moves", moves_bcd, 8'h02);
    check_eq("solved_mask", matched_mask, 16'h0208);

    // 4. full game, colours paired as (2k, 2k+1)
    for (int i = 0; i < 16; i++) set_color(i, 3'(i / 2));
    pulse_new_game();
    #1;
    check_eq("ng_moves", moves_bcd, 8'h00);
    check_eq("ng_mask", matched_mask, 16'h0);
    for (int k = 0; k < 8; k++) begin
      run_compare("game", 4'(2 * k), 4'(2 * k + 1), 4, 0, 16'h0, 0);
      check_eq("game_moves", moves_bcd, to_bcd(k + 1));
      check_eq("game_won_lvl", game_won, (k == 7) ? 1'b1 : 1'b0);
    end
    check_eq("game_mask", matched_mask, 16'hFFFF);
    pulse_new_game();
    #1;
    check_eq("clr_mask", matched_mask, 16'h0);
    check_eq("clr_moves", moves_bcd, 8'h00);
    check_eq("clr_won", game_won, 1'b0);
    check_eq("clr_pair", pair_match, 1'b0);

    // 5. BCD carries and saturation using mismatched pair (0,2)
    for (int n = 1; n <= 100; n++) begin
      run_compare("bcd", 4'd0, 4'd2, 4 + SHOW, 3 + SHOW, 16'h0005, 0);
      if (n == 9 || n == 10 || n == 19 || n == 20 || n == 99 || n == 100)
        check_eq("bcd_moves", moves_bcd, to_bcd(n));
    end

    // 6a. async reset during SHOW_WAIT
    @(negedge clk);
    first_idx  = 4'd0;
    second_idx = 4'd2;
    compare_en = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_moves", moves_bcd, 8'h00);
    @(negedge clk);
    rst        = 1'b0;
    compare_en = 1'b0;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (hide_valid || compare_done || busy) quiet++;
    end
    check_eq("arst_quiet", quiet, 0);

    // 6b. new_game during SHOW_WAIT
    run_compare("pre_ng", 4'd0, 4'd1, 4, 0, 16'h0, 0);
    check_eq("pre_ng_moves", moves_bcd, 8'h01);
    @(negedge clk);
    first_idx  = 4'd2;
    second_idx = 4'd4;
    compare_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ngw_busy", busy, 1'b0);
    check_eq("ngw_moves", moves_bcd, 8'h00);
    check_eq("ngw_mask", matched_mask, 16'h0);
    @(negedge clk);
    new_game   = 1'b0;
    compare_en = 1'b0;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (hide_valid || compare_done || busy) quiet++;
    end
    check_eq("ngw_quiet", quiet, 0);

    // 6c. compare_en held after done
    run_compare("hold", 4'd4, 4'd5, 4, 0, 16'h0, 6);
    check_eq("hold_moves", moves_bcd, 8'h01);
    check_eq("hold_mask", matched_mask, 16'h0030);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
